// File: rtl/rs_encoder.sv
// Systematic RS encoder over GF(2^8), run-time field and generator.
// Optional RS_ENCODER_LEN_CHECK_EN enables the message length guard.
module rs_encoder #(
  parameter int NSYM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        prim_poly,
  input  logic [8*NSYM-1:0] gen_poly_flat,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic              out_last,
  output logic              len_err
);

  localparam int CW = $clog2(NSYM + 1);

  typedef enum logic {MSG, PAR} state_t;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] p
  );
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = x[7] ? ((x << 1) ^ p) : (x << 1);
    end
    return acc;
  endfunction

  state_t          state, state_n;
  logic [7:0]      r [NSYM];
  logic [7:0]      prod [NSYM];
  logic [7:0]      fb;
  logic [CW-1:0]   cnt;
  logic            adv;
  logic            accept;
  logic            is_last;

  assign adv    = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign fb     = in_data ^ r[NSYM-1];

  for (genvar i = 0; i < NSYM; i++) begin : g_mul
    assign prod[i] = gf_mul(fb, gen_poly_flat[8*i +: 8], prim_poly);
  end

`ifdef RS_ENCODER_LEN_CHECK_EN
  localparam logic [7:0] LIMIT = 8'(255 - NSYM);
  logic [7:0] msg_cnt;
  logic       force_last;
  logic       len_err_q;

  assign force_last = accept && !in_last &&
                      (msg_cnt + 8'd1 == LIMIT);
  assign is_last    = in_last || force_last;
  assign len_err    = len_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_cnt   <= 8'd0;
      len_err_q <= 1'b0;
    end else if (accept) begin
      msg_cnt <= is_last ? 8'd0 : msg_cnt + 8'd1;
      if (force_last)
        len_err_q <= 1'b1;
      else if (msg_cnt == 8'd0)
        len_err_q <= 1'b0;
    end
  end
`else
  assign is_last = in_last;
  assign len_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MSG;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MSG: if (accept && is_last) state_n = PAR;
      PAR: if (adv && cnt == CW'(1)) state_n = MSG;
      default: state_n = MSG;
    endcase
  end

  always_comb begin
    in_ready = (state == MSG) && adv;
  end

  // Datapath: output register, LFSR remainder and parity countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_last   <= 1'b0;
      cnt        <= '0;
      for (int i = 0; i < NSYM; i++) r[i] <= 8'h00;
    end else if (state == MSG) begin
      if (accept) begin
        out_data   <= in_data;
        out_valid  <= 1'b1;
        out_parity <= 1'b0;
        out_last   <= 1'b0;
        r[0]       <= prod[0];
        for (int i = 1; i < NSYM; i++)
          r[i] <= r[i-1] ^ prod[i];
        if (is_last) cnt <= CW'(NSYM);
      end else if (adv) begin
        out_valid <= 1'b0;
      end
    end else if (adv) begin
      out_data   <= r[NSYM-1];
      out_valid  <= 1'b1;
      out_parity <= 1'b1;
      out_last   <= (cnt == CW'(1));
      r[0]       <= 8'h00;
      for (int i = 1; i < NSYM; i++)
        r[i] <= r[i-1];
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder (NSYM=4, poly 0x11D).
// Reference parity is polynomial long division using log/antilog tables.
module tb_rs_encoder;

  localparam int NSYM = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        prim_poly = 8'h1D;
  logic [8*NSYM-1:0] gen_poly_flat = {8'h0F, 8'h36, 8'h78, 8'h40};
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_parity;
  logic              out_last;
  logic              len_err;

  rs_encoder #(.NSYM(NSYM)) dut (
    .clk(clk), .rst(rst),
    .prim_poly(prim_poly), .gen_poly_flat(gen_poly_flat),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_last(out_last), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       l;
  } ob_t;

  ob_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   gap_en = 1'b0;
  bit   gap_started = 1'b0;
  int   gap_cnt = 0;
  int   rdy_low = 0;
  bit   was_stall = 1'b0;
  ob_t  held;

  logic [7:0] exp_tbl [0:254];
  int         log_tbl [0:255];

  function automatic void check(input string name,
                                input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  task automatic init_field();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_tbl[i] = x;
      log_tbl[x] = i;
      x = x[7] ? ((x << 1) ^ prim_poly) : (x << 1);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a,
                                     input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return exp_tbl[(log_tbl[a] + log_tbl[b]) % 255];
  endfunction

  // Remainder of M(x)*x^NSYM divided by the monic generator.
  task automatic push_cw(input logic [7:0] m[$]);
    logic [7:0] a[];
    logic [7:0] g [0:NSYM];
    int k;
    k = m.size();
    a = new[k + NSYM];
    g[0] = 8'h01;
    for (int j = 1; j <= NSYM; j++)
      g[j] = gen_poly_flat[8*(NSYM-j) +: 8];
    for (int i = 0; i < k + NSYM; i++)
      a[i] = (i < k) ? m[i] : 8'h00;
    for (int i = 0; i < k; i++)
      for (int j = 1; j <= NSYM; j++)
        a[i+j] = a[i+j] ^ mul(a[i], g[j]);
    for (int i = 0; i < k; i++)
      exp_q.push_back('{d: m[i], p: 1'b0, l: 1'b0});
    for (int j = 0; j < NSYM; j++)
      exp_q.push_back('{d: a[k+j], p: 1'b1, l: (j == NSYM-1)});
  endtask

  task automatic push_lit(input logic [7:0] v[$]);
    for (int i = 0; i < v.size(); i++)
      exp_q.push_back('{d: v[i], p: (i > 0), l: (i == v.size()-1)});
  endtask

  // Called at posedge+1; returns at posedge+1 after the final accept.
  task automatic drive(input logic [7:0] m[$], input bit end_last,
                       input int vprob);
    int idx;
    int waits;
    bit acc;
    idx = 0;
    waits = 0;
    while (idx < m.size()) begin
      in_valid = ($urandom_range(0, 99) < vprob);
      in_data  = in_valid ? m[idx] : 8'($urandom);
      in_last  = in_valid && end_last && (idx == m.size()-1);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        waits = 0;
      end else if (++waits > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: byte %0d of %0d", idx, m.size());
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d bytes missing", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void rand_msg(output logic [7:0] m[$],
                                   input int maxlen);
    int k;
    m.delete();
    k = $urandom_range(1, maxlen);
    for (int i = 0; i < k; i++) m.push_back(8'($urandom));
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      was_stall = 1'b0;
    end else if (mon_en) begin
      ob_t cur;
      cur = '{d: out_data, p: out_parity, l: out_last};
      if (was_stall) begin
        n_vec++;
        if (!out_valid || cur != held) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b %h expected v=1 %h",
                   out_valid, cur, held);
        end
      end
      was_stall = out_valid && !out_ready;
      held = cur;
      if (gap_en) begin
        if (!in_ready) rdy_low++;
        if (gap_started && exp_q.size() != 0 && !out_valid) gap_cnt++;
      end
      if (out_valid && out_ready) begin
        if (gap_en) gap_started = 1'b1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %h expected none", cur);
        end else begin
          ob_t e;
          e = exp_q.pop_front();
          n_vec++;
          if (cur != e) begin
            n_err++;
            $display("FAIL out_byte: got d=%h p=%0b l=%0b expected d=%h p=%0b l=%0b",
                     cur.d, cur.p, cur.l, e.d, e.p, e.l);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] m[$];
    logic [7:0] big[$];
    int c;
    init_field();

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_len_err", len_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_last", out_last, 0);
    @(posedge clk);
    #1;

    m = '{8'h01};
    push_lit('{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40});
    drive(m, 1'b1, 100);
    drain();
    m = '{8'h02};
    push_lit('{8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80});
    drive(m, 1'b1, 100);
    drain();
    m = '{8'h00};
    push_lit('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    drive(m, 1'b1, 100);
    drain();

    gap_en = 1'b1;
    gap_started = 1'b0;
    gap_cnt = 0;
    rdy_low = 0;
    for (int n = 0; n < 50; n++) begin
      rand_msg(m, 251);
      push_cw(m);
      drive(m, 1'b1, 100);
    end
    drain();
    gap_en = 1'b0;
    check("b2b_gap_cycles", gap_cnt, 0);
    check("b2b_in_ready_low", rdy_low, 50 * NSYM);

    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_msg(m, 40);
      push_cw(m);
      drive(m, 1'b1, 60);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    mon_en = 1'b0;
    m = '{8'h01};
    drive(m, 1'b1, 100);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(out_valid && out_parity) && c < 20);
    check("rst_test_reach_par", out_parity, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_parity", out_parity, 0);
    check("abort_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    m = '{8'h01};
    push_lit('{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40});
    drive(m, 1'b1, 100);
    drain();

    big.delete();
    for (int i = 0; i < 251; i++) big.push_back(8'($urandom));
    m = '{8'($urandom)};
`ifdef RS_ENCODER_LEN_CHECK_EN
    push_cw(big);
    push_cw(m);
    drive(big, 1'b0, 100);
    check("len_err_set", len_err, 1);
    drive(m, 1'b1, 100);
    check("len_err_clear", len_err, 0);
`else
    begin
      logic [7:0] all[$];
      all = big;
      all.push_back(m[0]);
      push_cw(all);
    end
    drive(big, 1'b0, 100);
    check("len_err_off_a", len_err, 0);
    drive(m, 1'b1, 100);
    check("len_err_off_b", len_err, 0);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^8) at the transmit end of the RS datapath; the decoder's syndrome, error-locator and root-search stages consume its codewords. Message bytes stream in on a valid/ready handshake and are forwarded unchanged. After the last message byte, the block emits NSYM parity bytes computed by an LFSR division by the generator polynomial. Field and generator coefficients are run-time inputs, so one netlist serves any primitive polynomial and code.

## Interface
- NSYM, 32, number of parity symbols (2 × MAX_ERRORS); legal range 2..64
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- prim_poly  input  8  field polynomial, low 8 bits (x^8 implied), e.g. 0x1D for 0x11D
- gen_poly_flat  input  8*NSYM  generator coefficients g_0..g_(NSYM-1); g_i at bits [8i+7:8i]; monic x^NSYM term implied
- in_data  input  8  message byte
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies the final message byte of a codeword
- in_ready  output  1  block accepts a byte this cycle
- out_data  output  8  codeword byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_parity  output  1  current out_data is a parity byte
- out_last  output  1  current out_data is the final parity byte
- len_err  output  1  message-length violation flag (see Configuration)

## Operation
- States: MSG (accepting message) and PAR (draining parity). Reset state is MSG.
- Parity register r[0..NSYM-1] is 8 bits per stage. It is cleared on reset and after each codeword.
- Output stage is one register: out_data, out_valid, out_parity, out_last. Define adv = !out_valid || out_ready.
- in_ready = (state==MSG) && adv. This is combinational and has no dependency on in_valid.
- Message byte accept (in_valid && in_ready):
  - out_data ← in_data, out_valid ← 1, out_parity ← 0, out_last ← 0.
  - fb = in_data ^ r[NSYM-1].
  - r[0] ← g_0·fb, and r[i] ← r[i-1] ^ g_i·fb for i ≥ 1.
  - If in_last: go to PAR and set cnt ← NSYM.
- PAR with adv:
  - out_data ← r[NSYM-1], out_valid ← 1, out_parity ← 1, out_last ← (cnt==1).
  - r shifts up: r[i] ← r[i-1], r[0] ← 0.
  - cnt ← cnt-1.
  - When cnt==1, go to MSG. The register is then all zero.
- Parity is emitted highest degree first (r[NSYM-1] first).
- If out_valid && !out_ready, nothing changes; all state holds.
- MSG with adv and no accept: out_valid ← 0.
- GF multiply: carry-less 8×8 product reduced modulo x^8 + prim_poly. Use NSYM parallel multiplier instances; there are no lookup tables.
- prim_poly and gen_poly_flat must be static from the first message byte through out_last. Changing them mid-codeword gives undefined parity.
- An empty message is impossible: in_last always accompanies a real byte.

## Timing
- All outputs reset to 0. state=MSG, cnt=0, r=0.
- Latency: an accepted byte appears on out_data the next cycle.
- The first parity byte is loaded the cycle the last message byte leaves the output (adv in PAR). There is no bubble.
- With out_ready held at 1, a codeword of K message bytes takes exactly K+NSYM consecutive output cycles.
- in_ready is low for the NSYM cycles spent in PAR. It rises combinationally in the cycle out_last is presented, so the next codeword can follow with zero gap.
- Backpressure may stall any byte, including the last message byte and any parity byte, for any number of cycles with no loss or duplication.
- rst asserted mid-codeword aborts it immediately: outputs drop to 0 and r clears. After release, the first in_valid byte starts a new codeword.

## Configuration
- RS_ENCODER_LEN_CHECK_EN defined:
  - An 8-bit counter counts message bytes per codeword.
  - If byte number 255-NSYM is accepted without in_last, it is treated as last: the block enters PAR, and len_err is set.
  - len_err is sticky and clears on the first accepted byte of the next codeword or on reset.
- Not defined: no counter, len_err tied to 0, and message length is unbounded (the caller's responsibility).

## Test plan
- NSYM=4, prim_poly=0x1D, g = {g0=0x40, g1=0x78, g2=0x36, g3=0x0F}; message {0x01, last} → output 0x01 then parity 0x0F, 0x36, 0x78, 0x40; out_last on 0x40 only; out_parity on the last four bytes.
- Same config, message {0x02} → 0x02 then 0x1E, 0x6C, 0xF0, 0x80. Message {0x00} → five 0x00 bytes.
- Random messages of 1..251 bytes, 50 codewords back-to-back with out_ready=1 → outputs match the software model; no gap between codewords; in_ready low exactly 4 cycles per codeword.
- Random out_ready (50%) and in_valid toggling → output byte stream identical to the stall-free run; each stalled byte holds stable.
- rst pulse during the 2nd parity byte, then message {0x01} → outputs cleared within the reset cycle; the next codeword gives 0x01, 0x0F, 0x36, 0x78, 0x40.
- With RS_ENCODER_LEN_CHECK_EN, NSYM=4, 252 bytes without in_last → byte 251 forces PAR and len_err=1; it clears on the next codeword's first byte. Without the macro, len_err stays 0.
